// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output stage and the SPI register file that feeds it.
// Register addresses are the map the register file decodes; the stage only consumes their contents.
package pwm_pkg;

    localparam int          PWM_WIDTH       = 8;
    localparam logic [7:0]  DUTY_FULL       = 8'hFF;
    localparam int          DEFAULT_CLK_DIV = 13;

    localparam logic [7:0]  ADDR_EN_OUT_7_0  = 8'h00;
    localparam logic [7:0]  ADDR_EN_OUT_15_8 = 8'h01;
    localparam logic [7:0]  ADDR_EN_PWM_7_0  = 8'h02;
    localparam logic [7:0]  ADDR_EN_PWM_15_8 = 8'h03;
    localparam logic [7:0]  ADDR_PWM_DUTY    = 8'h04;

    // A disabled pin is low; an enabled pin is static high unless PWM is enabled.
    function automatic logic pinNext(input logic enOut, input logic enPwm, input logic pwmLevel);
        return enOut ? (enPwm ? pwmLevel : 1'b1) : 1'b0;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, 8-bit step counter and the period-aligned duty shadow.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PWM_WIDTH-1:0] pwm_duty_cycle,
    output logic                 tick,
    output logic [PWM_WIDTH-1:0] step,
    output logic                 wrap,
    output logic [PWM_WIDTH-1:0] duty_shadow
);

    localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0]     r_prescaler;
    logic [PWM_WIDTH-1:0] r_step;
    logic [PWM_WIDTH-1:0] r_duty_shadow;

    // With CLK_DIV=1 the prescaler is pinned at zero, so tick stays high.
    assign tick        = (r_prescaler == PRE_LAST);
    assign wrap        = tick && (r_step == {PWM_WIDTH{1'b1}});
    assign step        = r_step;
    assign duty_shadow = r_duty_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler   <= '0;
            r_step        <= '0;
            r_duty_shadow <= '0;
        end else begin
            r_prescaler <= tick ? '0 : r_prescaler + 1'b1;
            if (tick) begin
                r_step <= r_step + 1'b1;
            end
            if (wrap) begin
                r_duty_shadow <= pwm_duty_cycle;
            end
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// Drives the 16 output pins low, static high or with the shared PWM waveform.
// Enables act on the next clock; duty only changes at period boundaries via the timebase shadow.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int PWM_WIDTH = pwm_pkg::PWM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           en_reg_out_7_0,
    input  logic [7:0]           en_reg_out_15_8,
    input  logic [7:0]           en_reg_pwm_7_0,
    input  logic [7:0]           en_reg_pwm_15_8,
    input  logic [PWM_WIDTH-1:0] pwm_duty_cycle,
    output logic [7:0]           out_7_0,
    output logic [7:0]           out_15_8,
    output logic                 period_start
);

    logic                 w_tick;
    logic                 w_wrap;
    logic [PWM_WIDTH-1:0] w_step;
    logic [PWM_WIDTH-1:0] w_duty_shadow;
    logic                 w_pwm_level;
    logic [15:0]          w_en_out;
    logic [15:0]          w_en_pwm;
    logic [15:0]          w_next_out;

    logic [15:0]          r_out;
    logic                 r_period_start;

    pwm_timebase #(
        .CLK_DIV(CLK_DIV)
    ) u_timebase (
        .clk            (clk),
        .rst            (rst),
        .pwm_duty_cycle (pwm_duty_cycle),
        .tick           (w_tick),
        .step           (w_step),
        .wrap           (w_wrap),
        .duty_shadow    (w_duty_shadow)
    );

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Full-scale duty is special-cased so 0xFF stays high through step 255 with no gap.
    assign w_pwm_level = (w_duty_shadow == DUTY_FULL) ? 1'b1 : (w_step < w_duty_shadow);

    always_comb begin
        w_next_out = '0;
        for (int i = 0; i < 16; i++) begin
            w_next_out[i] = pinNext(w_en_out[i], w_en_pwm[i], w_pwm_level);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_next_out;
            r_period_start <= w_wrap;
        end
    end

    assign out_7_0      = r_out[7:0];
    assign out_15_8     = r_out[15:8];
    assign period_start = r_period_start;

endmodule
